// File: rtl/dp_pkg.sv
// dp_pkg: shared constants for the dp_core_param datapath.
//   - Bus source offsets (relative to NREGS) and the resulting codes for the
//     default 16-register configuration.
//   - ALU operation encodings.
//   - Memory handshake FSM state type and state constants.
package dp_pkg;

  // Bus sources that follow the general registers, as offsets from NREGS.
  localparam int SRC_OFF_HI   = 0;
  localparam int SRC_OFF_LO   = 1;
  localparam int SRC_OFF_ZHI  = 2;
  localparam int SRC_OFF_ZLO  = 3;
  localparam int SRC_OFF_PC   = 4;
  localparam int SRC_OFF_MDR  = 5;
  localparam int SRC_OFF_IN   = 6;
  localparam int SRC_OFF_C    = 7;

  // Absolute codes for the default configuration (NREGS = 16).
  localparam int DP_NREGS_DEF = 16;
  localparam int SRC_HI  = DP_NREGS_DEF + SRC_OFF_HI;
  localparam int SRC_LO  = DP_NREGS_DEF + SRC_OFF_LO;
  localparam int SRC_ZHI = DP_NREGS_DEF + SRC_OFF_ZHI;
  localparam int SRC_ZLO = DP_NREGS_DEF + SRC_OFF_ZLO;
  localparam int SRC_PC  = DP_NREGS_DEF + SRC_OFF_PC;
  localparam int SRC_MDR = DP_NREGS_DEF + SRC_OFF_MDR;
  localparam int SRC_IN  = DP_NREGS_DEF + SRC_OFF_IN;
  localparam int SRC_C   = DP_NREGS_DEF + SRC_OFF_C;

  // ALU operation codes.
  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_SHR   = 4'd4;
  localparam logic [3:0] ALU_SHL   = 4'd5;
  localparam logic [3:0] ALU_ROR   = 4'd6;
  localparam logic [3:0] ALU_ROL   = 4'd7;
  localparam logic [3:0] ALU_NEG   = 4'd8;
  localparam logic [3:0] ALU_NOT   = 4'd9;
  localparam logic [3:0] ALU_INCPC = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;
  localparam logic [3:0] ALU_DIV   = 4'd12;

  // Memory handshake FSM.
  typedef logic [1:0] mem_state_t;
  localparam mem_state_t MEM_IDLE = 2'd0;
  localparam mem_state_t MEM_RD   = 2'd1;
  localparam mem_state_t MEM_WR   = 2'd2;

endpackage

// File: rtl/dp_div_iter.sv
// dp_div_iter: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset (aborts a division)
//   start_i        launch; ignored while busy
//   dividend_i     dividend, sampled on start
//   divisor_i      divisor, sampled on start
//   busy_o         iterations in progress (WIDTH cycles)
//   done_o         one-cycle pulse, the cycle after the result is produced
//   fin_o          high on the clock edge that produces the result, so the
//                  parent can capture quotient_o/remainder_o on that edge
//   quotient_o     result quotient, valid while fin_o is high
//   remainder_o    result remainder, valid while fin_o is high
// A zero divisor finishes at the start edge with quotient all-ones and
// remainder equal to the dividend.
module dp_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fin_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic             run_q;
  logic             done_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             last;
  logic             zero_start;

  // Shift the next dividend bit into the partial remainder and try to
  // subtract. The partial remainder is always below the divisor, so the
  // trial value is below twice the divisor and the top bit of the W+1-bit
  // difference is a reliable borrow flag.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvsr_q};
  assign ge    = ~diff[WIDTH];
  assign rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_d = {quo_q[WIDTH-2:0], ge};

  assign last       = run_q && (cnt_q == CNTW'(WIDTH - 1));
  assign zero_start = start_i && !run_q && (divisor_i == '0);

  assign fin_o       = zero_start || last;
  assign quotient_o  = zero_start ? '1 : quo_d;
  assign remainder_o = zero_start ? dividend_i : rem_d;
  assign busy_o      = run_q;
  assign done_o      = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      done_q <= fin_o;
      if (run_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          run_q <= 1'b0;
        end
      end else if (start_i && (divisor_i != '0)) begin
        run_q  <= 1'b1;
        cnt_q  <= '0;
        rem_q  <= '0;
        quo_q  <= dividend_i;
        dvsr_q <= divisor_i;
      end
    end
  end

endmodule

// File: rtl/dp_core_param.sv
// dp_core_param: single-bus CPU datapath driven cycle-by-cycle by a control
// unit. Holds the register file, PC/IR/MAR/MDR/Y/Z/HI/LO, ALU, an iterative
// divider, a req/ack memory handshake and the in/out ports.
// Ports:
//   clk, clear            clock, synchronous active-low reset
//   bus_src, ba_out       encoded bus source; ba_out forces source 0 to zero
//   r_in, *_in, out_en    destination load enables (all sample the bus)
//   alu_op, alu_start     ALU operation; alu_start launches DIV
//   alu_busy, alu_done    divider status
//   mem_rd, mem_wr        memory request pulses
//   mem_req, mem_we       memory request and write qualifier
//   mem_addr, mem_wdata   MAR and MDR
//   mem_rdata, mem_ack    memory read data and completion
//   mem_busy              memory transaction outstanding
//   in_port, in_strobe    input port and its latch strobe
//   out_port              output port register
//   c_sign_ext            immediate bus source
//   bus, ir, z            bus value, instruction register, Z register
module dp_core_param
  import dp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int SRCW  = 5
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [SRCW-1:0]      bus_src,
  input  logic [NREGS-1:0]     r_in,
  input  logic                 pc_in,
  input  logic                 ir_in,
  input  logic                 mar_in,
  input  logic                 y_in,
  input  logic                 hi_in,
  input  logic                 lo_in,
  input  logic                 z_in,
  input  logic                 mdr_in,
  input  logic                 out_en,
  input  logic                 ba_out,
  input  logic [3:0]           alu_op,
  input  logic                 alu_start,
  output logic                 alu_busy,
  output logic                 alu_done,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_busy,
  input  logic [WIDTH-1:0]     in_port,
  input  logic                 in_strobe,
  output logic [WIDTH-1:0]     out_port,
  input  logic [WIDTH-1:0]     c_sign_ext,
  output logic [WIDTH-1:0]     bus,
  output logic [WIDTH-1:0]     ir,
  output logic [2*WIDTH-1:0]   z
);

  localparam int IDXW = $clog2(NREGS);
  localparam int SHW  = $clog2(WIDTH);

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
  logic [WIDTH-1:0]   inport_q, outport_q;
  logic [2*WIDTH-1:0] z_q;
  mem_state_t         mstate_q, mstate_d;

  logic [WIDTH-1:0]   bus_v;
  logic [31:0]        src_ext;

  // Bus source decode: general registers first, then the fixed sources.
  assign src_ext = 32'(bus_src);

  always_comb begin
    bus_v = '0;
    if (src_ext < 32'(NREGS)) begin
      if (!(ba_out && (src_ext == 32'd0))) begin
        bus_v = regs_q[bus_src[IDXW-1:0]];
      end
    end else begin
      case (src_ext - 32'(NREGS))
        32'(SRC_OFF_HI):  bus_v = hi_q;
        32'(SRC_OFF_LO):  bus_v = lo_q;
        32'(SRC_OFF_ZHI): bus_v = z_q[2*WIDTH-1:WIDTH];
        32'(SRC_OFF_ZLO): bus_v = z_q[WIDTH-1:0];
        32'(SRC_OFF_PC):  bus_v = pc_q;
        32'(SRC_OFF_MDR): bus_v = mdr_q;
        32'(SRC_OFF_IN):  bus_v = inport_q;
        32'(SRC_OFF_C):   bus_v = c_sign_ext;
        default:          bus_v = '0;
      endcase
    end
  end

  // Single-cycle ALU: A = Y, B = bus.
  logic [SHW-1:0]            sh;
  logic [2*WIDTH-1:0]        rot_r, rot_l;
  logic signed [2*WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [WIDTH-1:0]          alu_lo;
  logic [2*WIDTH-1:0]        alu_res;

  assign sh    = bus_v[SHW-1:0];
  // Rotates shift a doubled copy so the wrapped bits fall into place.
  assign rot_r = {y_q, y_q} >> sh;
  assign rot_l = {y_q, y_q} << sh;
  assign mul_a = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q});
  assign mul_b = $signed({{WIDTH{bus_v[WIDTH-1]}}, bus_v});
  assign mul_p = mul_a * mul_b;

  always_comb begin
    alu_lo = '0;
    case (alu_op)
      ALU_AND:   alu_lo = y_q & bus_v;
      ALU_OR:    alu_lo = y_q | bus_v;
      ALU_ADD:   alu_lo = y_q + bus_v;
      ALU_SUB:   alu_lo = y_q - bus_v;
      ALU_SHR:   alu_lo = y_q >> sh;
      ALU_SHL:   alu_lo = y_q << sh;
      ALU_ROR:   alu_lo = rot_r[WIDTH-1:0];
      ALU_ROL:   alu_lo = rot_l[2*WIDTH-1:WIDTH];
      ALU_NEG:   alu_lo = '0 - bus_v;
      ALU_NOT:   alu_lo = ~bus_v;
      ALU_INCPC: alu_lo = bus_v + 1'b1;
      default:   alu_lo = '0;
    endcase
  end

  assign alu_res = (alu_op == ALU_MUL) ? $unsigned(mul_p) : {{WIDTH{1'b0}}, alu_lo};

  // Iterative divider.
  logic             div_start, div_busy, div_done, div_fin;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign div_start = alu_start && (alu_op == ALU_DIV) && !div_busy;

  dp_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (clear),
    .start_i     (div_start),
    .dividend_i  (y_q),
    .divisor_i   (bus_v),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .fin_o       (div_fin),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign alu_busy = div_busy;
  assign alu_done = div_done;

  // Memory handshake FSM.
  always_comb begin
    mstate_d = mstate_q;
    case (mstate_q)
      MEM_IDLE: begin
        if (mem_rd) begin
          mstate_d = MEM_RD;
        end else if (mem_wr) begin
          mstate_d = MEM_WR;
        end
      end
      MEM_RD, MEM_WR: begin
        if (mem_ack) begin
          mstate_d = MEM_IDLE;
        end
      end
      default: mstate_d = MEM_IDLE;
    endcase
  end

  assign mem_req   = (mstate_q != MEM_IDLE);
  assign mem_busy  = mem_req;
  assign mem_we    = (mstate_q == MEM_WR);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

  // Register file.
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (r_in[i]) begin
          regs_q[i] <= bus_v;
        end
      end
    end
  end

  // Special registers, ports and memory state.
  always_ff @(posedge clk) begin
    if (!clear) begin
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      z_q       <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      mstate_q  <= MEM_IDLE;
    end else begin
      mstate_q <= mstate_d;
      if (pc_in)     pc_q      <= bus_v;
      if (ir_in)     ir_q      <= bus_v;
      if (mar_in)    mar_q     <= bus_v;
      if (y_in)      y_q       <= bus_v;
      if (hi_in)     hi_q      <= bus_v;
      if (lo_in)     lo_q      <= bus_v;
      if (out_en)    outport_q <= bus_v;
      if (in_strobe) inport_q  <= in_port;
      // Returning read data beats a bus load in the same cycle.
      if ((mstate_q == MEM_RD) && mem_ack) begin
        mdr_q <= mem_rdata;
      end else if (mdr_in) begin
        mdr_q <= bus_v;
      end
      // A finishing division owns Z; ALU loads are locked out while busy.
      if (div_fin) begin
        z_q <= {div_rem, div_quo};
      end else if (z_in && !div_busy) begin
        z_q <= alu_res;
      end
    end
  end

  assign bus      = bus_v;
  assign ir       = ir_q;
  assign z        = z_q;
  assign out_port = outport_q;

endmodule

// File: tb/tb_dp_core_param.sv
module tb_dp_core_param;
  import dp_pkg::*;

  localparam int W  = 32;
  localparam int NR = 16;
  localparam int SW = 5;

  logic            clk;
  logic            clear;
  logic [SW-1:0]   bus_src;
  logic [NR-1:0]   r_in;
  logic            pc_in, ir_in, mar_in, y_in, hi_in, lo_in, z_in, mdr_in, out_en;
  logic            ba_out;
  logic [3:0]      alu_op;
  logic            alu_start, alu_busy, alu_done;
  logic            mem_rd, mem_wr, mem_req, mem_we, mem_ack, mem_busy;
  logic [W-1:0]    mem_addr, mem_wdata, mem_rdata;
  logic [W-1:0]    in_port, out_port, c_sign_ext, bus, ir;
  logic            in_strobe;
  logic [2*W-1:0]  z;

  dp_core_param #(.WIDTH(W), .NREGS(NR), .SRCW(SW)) dut (
    .clk(clk), .clear(clear), .bus_src(bus_src), .r_in(r_in),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .y_in(y_in),
    .hi_in(hi_in), .lo_in(lo_in), .z_in(z_in), .mdr_in(mdr_in),
    .out_en(out_en), .ba_out(ba_out), .alu_op(alu_op),
    .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_busy(mem_busy), .in_port(in_port),
    .in_strobe(in_strobe), .out_port(out_port), .c_sign_ext(c_sign_ext),
    .bus(bus), .ir(ir), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] obs);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty observed=0x%0h", tag, obs);
    end else begin
      chk(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_src = '0; r_in = '0; pc_in = 0; ir_in = 0; mar_in = 0; y_in = 0;
    hi_in = 0; lo_in = 0; z_in = 0; mdr_in = 0; out_en = 0; ba_out = 0;
    alu_op = ALU_AND; alu_start = 0; mem_rd = 0; mem_wr = 0; mem_ack = 0;
    mem_rdata = '0; in_port = '0; in_strobe = 0; c_sign_ext = '0;
  endtask

  task automatic drive_c(input logic [W-1:0] v);
    bus_src = SW'(SRC_C);
    c_sign_ext = v;
  endtask

  task automatic load_reg(input int idx, input logic [W-1:0] v);
    drive_c(v);
    r_in = '0;
    r_in[idx] = 1'b1;
    step();
    r_in = '0;
  endtask

  task automatic load_y(input logic [W-1:0] v);
    drive_c(v);
    y_in = 1;
    step();
    y_in = 0;
  endtask

  task automatic read_bus(input int src, input string tag, input logic [W-1:0] exp);
    bus_src = SW'(src);
    #1;
    chk(tag, 64'(bus), 64'(exp));
  endtask

  task automatic alu1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input string tag, input logic [63:0] exp);
    load_y(a);
    drive_c(b);
    alu_op = op;
    z_in = 1;
    sb_q.push_back(exp);
    step();
    z_in = 0;
    pop_chk(tag, z);
  endtask

  task automatic div_run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [63:0] z_before;
    int cyc;
    int busy_cnt;
    load_y(a);
    z_before = z;
    drive_c(b);
    alu_op = ALU_DIV;
    alu_start = 1;
    sb_q.push_back((b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b});
    step();
    alu_start = 0;
    if (b == 0) begin
      chk({tag, "_done0"}, 64'(alu_done), 64'd1);
      chk({tag, "_busy0"}, 64'(alu_busy), 64'd0);
      pop_chk({tag, "_z"}, z);
    end else begin
      cyc = 1;
      busy_cnt = 0;
      while (!alu_done && cyc < 60) begin
        if (alu_busy) busy_cnt++;
        if (cyc == 6) chk({tag, "_zin_ignored"}, z, z_before);
        alu_start = (cyc == 5);
        z_in = (cyc == 5);
        step();
        cyc++;
      end
      alu_start = 0;
      z_in = 0;
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(W + 1));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
      chk({tag, "_busy_at_done"}, 64'(alu_busy), 64'd0);
      pop_chk({tag, "_z"}, z);
    end
    step();
    chk({tag, "_done_pulse"}, 64'(alu_done), 64'd0);
  endtask

  initial begin
    int req_cnt;
    int done_seen;

    idle();
    clear = 0;
    step();
    step();
    clear = 1;

    // Reset clears registers and Z.
    load_reg(3, 32'hDEAD_BEEF);
    read_bus(3, "r3_preload", 32'hDEAD_BEEF);
    alu1(ALU_OR, 32'h5, 32'h3, "or_pre_reset", 64'h7);
    drive_c(32'h77); ir_in = 1; step(); ir_in = 0;
    clear = 0;
    step();
    clear = 1;
    idle();
    read_bus(3, "reset_r3", 32'h0);
    chk("reset_z", z, 64'h0);
    chk("reset_ir", 64'(ir), 64'h0);
    chk("reset_mem_req", 64'(mem_req), 64'h0);
    chk("reset_alu_busy", 64'(alu_busy), 64'h0);
    chk("reset_alu_done", 64'(alu_done), 64'h0);

    // ba_out on source 0.
    load_reg(0, 32'h5);
    ba_out = 1;
    read_bus(0, "ba_out_zero", 32'h0);
    ba_out = 0;
    read_bus(0, "ba_out_off", 32'h5);

    // ALU ops.
    load_y(32'h7FFF_FFFF);
    load_reg(1, 32'h1);
    bus_src = 1; alu_op = ALU_ADD; z_in = 1;
    sb_q.push_back(64'h0000_0000_8000_0000);
    step();
    z_in = 0;
    pop_chk("add_z", z);
    read_bus(SRC_ZLO, "add_zlo_bus", 32'h8000_0000);
    read_bus(SRC_ZHI, "add_zhi_bus", 32'h0);
    alu1(ALU_MUL, 32'hFFFF_FFFE, 32'h3, "mul_neg", 64'hFFFF_FFFF_FFFF_FFFA);
    alu1(ALU_MUL, 32'h8000_0000, 32'h8000_0000, "mul_minmin", 64'h4000_0000_0000_0000);
    alu1(ALU_SUB, 32'h5, 32'h7, "sub_wrap", 64'h0000_0000_FFFF_FFFE);
    alu1(ALU_AND, 32'hF0F0_1234, 32'hFF00_FF00, "and", 64'h0000_0000_F000_1200);
    alu1(ALU_SHR, 32'h8000_0000, 32'd31, "shr31", 64'h1);
    alu1(ALU_SHL, 32'h1, 32'd36, "shl_amt_masked", 64'h10);
    alu1(ALU_ROR, 32'h8000_0001, 32'd4, "ror4", 64'h1800_0000);
    alu1(ALU_ROL, 32'h8000_0001, 32'd4, "rol4", 64'h18);
    alu1(ALU_NEG, 32'h0, 32'h1, "neg", 64'h0000_0000_FFFF_FFFF);
    alu1(ALU_NOT, 32'h0, 32'h0, "not", 64'h0000_0000_FFFF_FFFF);
    alu1(ALU_INCPC, 32'h0, 32'hFFFF_FFFF, "incpc_wrap", 64'h0);

    // Multiple destinations in one cycle, and the input port.
    drive_c(32'hA5A5_0001);
    pc_in = 1; ir_in = 1; out_en = 1; hi_in = 1;
    step();
    pc_in = 0; ir_in = 0; out_en = 0; hi_in = 0;
    chk("multi_ir", 64'(ir), 64'hA5A5_0001);
    chk("multi_out", 64'(out_port), 64'hA5A5_0001);
    read_bus(SRC_PC, "multi_pc", 32'hA5A5_0001);
    read_bus(SRC_HI, "multi_hi", 32'hA5A5_0001);
    in_port = 32'h55AA; in_strobe = 1;
    step();
    in_strobe = 0; in_port = '0;
    read_bus(SRC_IN, "inport", 32'h55AA);

    // Memory read with three wait cycles; second request ignored.
    drive_c(32'h10); mar_in = 1; step(); mar_in = 0;
    mem_rd = 1;
    sb_q.push_back(64'h1234);
    step();
    mem_rd = 0;
    chk("rd_addr", 64'(mem_addr), 64'h10);
    chk("rd_we", 64'(mem_we), 64'h0);
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req) req_cnt++;
      mem_rd = (i == 1);
      step();
    end
    if (mem_req) req_cnt++;
    mem_rd = 0;
    drive_c(32'hFFFF); mdr_in = 1;
    mem_ack = 1; mem_rdata = 32'h1234;
    step();
    mem_ack = 0; mdr_in = 0; mem_rdata = '0;
    if (mem_req) req_cnt++;
    chk("rd_req_cycles", 64'(req_cnt), 64'd4);
    chk("rd_busy_after", 64'(mem_busy), 64'h0);
    bus_src = SW'(SRC_MDR); #1;
    pop_chk("rd_mdr", 64'(bus));
    step();
    chk("rd_no_second_req", 64'(mem_req), 64'h0);
    mem_ack = 1; mem_rdata = 32'h999;
    step();
    mem_ack = 0;
    read_bus(SRC_MDR, "ack_in_idle", 32'h1234);

    // Write acknowledged on its first request cycle.
    drive_c(32'hCAFE); mdr_in = 1; step(); mdr_in = 0;
    drive_c(32'h20); mar_in = 1; mem_wr = 1; step(); mar_in = 0; mem_wr = 0;
    chk("wr_req", 64'(mem_req), 64'h1);
    chk("wr_we", 64'(mem_we), 64'h1);
    chk("wr_wdata", 64'(mem_wdata), 64'hCAFE);
    chk("wr_addr", 64'(mem_addr), 64'h20);
    mem_ack = 1; step(); mem_ack = 0;
    chk("wr_busy_after", 64'(mem_busy), 64'h0);

    // Division.
    div_run(32'd100, 32'd7, "div_100_7");
    div_run(32'd100, 32'd0, "div_by0");
    div_run(32'hFFFF_FFFF, 32'h10, "div_max_16");
    div_run(32'd5, 32'd9, "div_small");

    // Reset during DIV and WR, then a late ack.
    load_y(32'd100);
    drive_c(32'd7); alu_op = ALU_DIV; alu_start = 1; step(); alu_start = 0;
    step(); step();
    drive_c(32'h30); mar_in = 1; mem_wr = 1; step(); mar_in = 0; mem_wr = 0;
    chk("mid_wr_req", 64'(mem_req), 64'h1);
    chk("mid_div_busy", 64'(alu_busy), 64'h1);
    clear = 0; step(); clear = 1;
    mem_ack = 1; mem_rdata = 32'hBAD; step(); mem_ack = 0;
    chk("mid_alu_busy", 64'(alu_busy), 64'h0);
    chk("mid_mem_busy", 64'(mem_busy), 64'h0);
    chk("mid_z", z, 64'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (alu_done) done_seen++;
      step();
    end
    chk("mid_no_done", 64'(done_seen), 64'h0);
    read_bus(SRC_MDR, "mid_mdr", 32'h0);

    // Reset during RD: late ack must not reach MDR; FSM must be IDLE.
    mem_rd = 1; step(); mem_rd = 0;
    clear = 0; step(); clear = 1;
    mem_ack = 1; mem_rdata = 32'hBAD; step(); mem_ack = 0;
    read_bus(SRC_MDR, "mid_rd_mdr", 32'h0);
    mem_wr = 1; step(); mem_wr = 0;
    chk("post_reset_idle_wr", 64'(mem_we), 64'h1);
    mem_ack = 1; step(); mem_ack = 0;
    chk("post_reset_wr_done", 64'(mem_req), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
